// File: rtl/sharpen_window_scheduler_if.sv
// sharpen_window_scheduler_if: source-memory, kernel-engine and destination-memory buses of the scheduler.
interface sharpen_window_scheduler_if #(
  parameter int ADDR_W = 18,
  parameter int RES_W  = 12
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              win_valid;
  logic              win_ready;
  logic [71:0]       win_data;
  logic              res_valid;
  logic [RES_W-1:0]  res_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  modport master (
    output rd_en, rd_addr, win_valid, win_data, wr_en, wr_addr, wr_data,
    input  rd_data, win_ready, res_valid, res_data
  );
  modport slave (
    input  rd_en, rd_addr, win_valid, win_data, wr_en, wr_addr, wr_data,
    output rd_data, win_ready, res_valid, res_data
  );
endinterface

// File: rtl/sharpen_window_scheduler.sv
// sharpen_window_scheduler: raster-walks a frame, fetching edge-replicated 3x3 windows for the
// sharpen engine and writing its clamped results back, one window in flight at a time.
module sharpen_window_scheduler #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int ADDR_W = 18,
  parameter int RES_W  = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  sharpen_window_scheduler_if.master bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] DRAIN    = 3'd2;
  localparam logic [2:0] PRESENT  = 3'd3;
  localparam logic [2:0] WAIT_RES = 3'd4;
  localparam logic [2:0] WRITE    = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;
  logic [2:0]    state;
  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, ry;
  logic [1:0]    tr, tc;
  logic [71:0]   win;
  logic [7:0]    res;
  logic          cap;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      tr    <= '0;
      tc    <= '0;
      win   <= '0;
      res   <= '0;
      cap   <= 1'b0;
    end else begin
      cap <= state == FETCH;
      // taps return in k order, so shifting in from the top leaves tap 0 in the low byte
      if (cap) win <= {bus.rd_data, win[71:8]};
      case (state)
        IDLE: if (start) begin
          x     <= '0;
          y     <= '0;
          state <= FETCH;
        end
        FETCH: begin
          tc <= tc == 2'd2 ? 2'd0 : tc + 2'd1;
          tr <= tc == 2'd2 ? tr + 2'd1 : tr;
          if (tr == 2'd2 && tc == 2'd2) begin
            tr    <= '0;
            tc    <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: state <= PRESENT;
        PRESENT: if (bus.win_ready) state <= WAIT_RES;
        WAIT_RES: if (bus.res_valid) begin
          res   <= bus.res_data[RES_W-1] ? 8'd0 : |bus.res_data[RES_W-2:8] ? 8'd255 : bus.res_data[7:0];
          state <= WRITE;
        end
        WRITE: begin
          x     <= x == X_MAX ? '0 : x + 1'b1;
          y     <= x == X_MAX ? y + 1'b1 : y;
          state <= (x == X_MAX && y == Y_MAX) ? DONE : FETCH;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    ry            = tr == 2'd0 ? (y == '0 ? y : y - 1'b1) : tr == 2'd1 ? y : (y == Y_MAX ? y : y + 1'b1);
    cx            = tc == 2'd0 ? (x == '0 ? x : x - 1'b1) : tc == 2'd1 ? x : (x == X_MAX ? x : x + 1'b1);
    busy          = state != IDLE;
    done          = state == DONE;
    bus.rd_en     = state == FETCH;
    bus.rd_addr   = bus.rd_en ? ADDR_W'(ry) * ADDR_W'(IMG_W) + ADDR_W'(cx) : '0;
    bus.win_valid = state == PRESENT;
    bus.win_data  = win;
    bus.wr_en     = state == WRITE;
    bus.wr_addr   = bus.wr_en ? ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x) : '0;
    bus.wr_data   = bus.wr_en ? res : '0;
  end
endmodule
